fir_coef_ctrl: RTL and testbench

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_coef_ctrl_if.sv | 27 ++
 rtl/fir_coef_shadow.sv | 34 +++
 rtl/fir_coef_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default datapath geometry and the coefficient-load FSM states.
package fir_pkg;

  localparam int FIR_NUMBER_OF_TAPS = 63;
  localparam int FIR_DATA_WIDTH     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SWAP   = 2'd2,
    SETTLE = 2'd3
  } fir_ctrl_state_e;

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Coefficient-load handshake plus active-bank/status bus between a loader and fir_coef_ctrl.
interface fir_coef_ctrl_if import fir_pkg::*; #(
  parameter int NUMBER_OF_TAPS = FIR_NUMBER_OF_TAPS,
  parameter int DATA_WIDTH     = FIR_DATA_WIDTH
);

  logic                         load_start;
  logic                         coef_valid;
  logic signed [DATA_WIDTH-1:0] coef_data;
  logic                         coef_ready;
  logic signed [DATA_WIDTH-1:0] h [NUMBER_OF_TAPS];
  logic                         busy;
  logic                         out_valid;
  logic                         swap_done;
  logic                         load_err;

  modport master (
    output load_start, coef_valid, coef_data,
    input  coef_ready, h, busy, out_valid, swap_done, load_err
  );

  modport slave (
    input  load_start, coef_valid, coef_data,
    output coef_ready, h, busy, out_valid, swap_done, load_err
  );

endinterface

// File: rtl/fir_coef_shadow.sv
// Shadow coefficient bank: one indexed write port, whole bank readable at once for the atomic swap.
module fir_coef_shadow import fir_pkg::*; #(
  parameter int NUMBER_OF_TAPS = FIR_NUMBER_OF_TAPS,
  parameter int DATA_WIDTH     = FIR_DATA_WIDTH,
  parameter int ADDR_WIDTH     = $clog2(FIR_NUMBER_OF_TAPS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] rd_bank [NUMBER_OF_TAPS]
);

  logic signed [DATA_WIDTH-1:0] mem_r [NUMBER_OF_TAPS];

  // Indexed beat write; reset clears every entry so a discarded load leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
        if (wr_addr == ADDR_WIDTH'(i)) begin
          mem_r[i] <= wr_data;
        end
      end
    end
  end

  assign rd_bank = mem_r;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient reload controller: streams taps into a shadow bank, swaps it atomically into h,
// then holds out_valid low while the FIR pipeline settles. Option macro: FIR_COEF_CHECKSUM_EN.
module fir_coef_ctrl import fir_pkg::*; #(
  parameter int NUMBER_OF_TAPS = FIR_NUMBER_OF_TAPS,
  parameter int DATA_WIDTH     = FIR_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_coef_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(NUMBER_OF_TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUMBER_OF_TAPS - 1);

  typedef logic signed [DATA_WIDTH-1:0] coef_t;

  fir_ctrl_state_e  state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             boot_r, boot_s;
  logic             accept_s, shadow_we_s, bank_we_s, out_valid_s;
  logic             coef_ready_r, busy_r, out_valid_r, swap_done_r;
  coef_t            shadow_s    [NUMBER_OF_TAPS];
  coef_t            bank_load_s [NUMBER_OF_TAPS];
  coef_t            bank_r      [NUMBER_OF_TAPS];

`ifdef FIR_COEF_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CSUM_BEAT = CNT_W'(NUMBER_OF_TAPS);
  coef_t sum_r, sum_s;
  logic  load_err_s, load_err_r;

  function automatic coef_t csum_add(input coef_t acc, input coef_t beat);
    return acc + beat;
  endfunction
`endif

  assign accept_s = (state_r == LOAD) && bus.coef_valid;

  fir_coef_shadow #(
    .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (CNT_W)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (shadow_we_s),
    .wr_addr (cnt_r),
    .wr_data (bus.coef_data),
    .rd_bank (shadow_s)
  );

  // New active bank; without a checksum beat the last tap bypasses the shadow so h is complete in SWAP.
  always_comb begin
    bank_load_s = shadow_s;
`ifndef FIR_COEF_CHECKSUM_EN
    bank_load_s[NUMBER_OF_TAPS-1] = bus.coef_data;
`endif
  end

  // Next-state logic; cnt is the beat index in LOAD and the settle count in SETTLE.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    boot_s      = boot_r;
    shadow_we_s = 1'b0;
    bank_we_s   = 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
    sum_s       = sum_r;
    load_err_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (boot_r) begin
          // The post-reset IDLE cycle already counts as the first settle cycle.
          state_s = SETTLE;
          cnt_s   = CNT_W'(1);
          boot_s  = 1'b0;
        end else if (bus.load_start) begin
          state_s = LOAD;
          cnt_s   = '0;
`ifdef FIR_COEF_CHECKSUM_EN
          sum_s   = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
`ifdef FIR_COEF_CHECKSUM_EN
          if (cnt_r == CSUM_BEAT) begin
            cnt_s = '0;
            if (bus.coef_data == sum_r) begin
              state_s   = SWAP;
              bank_we_s = 1'b1;
            end else begin
              state_s    = IDLE;
              load_err_s = 1'b1;
            end
          end else begin
            shadow_we_s = 1'b1;
            sum_s       = csum_add(sum_r, bus.coef_data);
            cnt_s       = cnt_r + CNT_W'(1);
          end
`else
          shadow_we_s = 1'b1;
          if (cnt_r == LAST_TAP) begin
            state_s   = SWAP;
            bank_we_s = 1'b1;
            cnt_s     = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`endif
        end else begin
          state_s = LOAD;
        end
      end
      SWAP: begin
        state_s = SETTLE;
        cnt_s   = '0;
      end
      SETTLE: begin
        if (cnt_r >= LAST_TAP) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // out_valid decoded from the next state so the registered flag lines up with the state.
  always_comb begin
    out_valid_s = 1'b0;
    case (state_s)
      LOAD:    out_valid_s = 1'b1;
      IDLE:    out_valid_s = !boot_s;
      default: out_valid_s = 1'b0;
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      boot_r       <= 1'b1;
      coef_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      swap_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      boot_r       <= boot_s;
      coef_ready_r <= (state_s == LOAD);
      busy_r       <= (state_s != IDLE);
      out_valid_r  <= out_valid_s;
      swap_done_r  <= (state_s == SWAP);
    end
  end

  // Active bank: every tap is replaced on the same edge, never piecemeal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
        bank_r[i] <= '0;
      end
    end else if (bank_we_s) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
        bank_r[i] <= bank_load_s[i];
      end
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  // Running checksum and discard pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r      <= '0;
      load_err_r <= 1'b0;
    end else begin
      sum_r      <= sum_s;
      load_err_r <= load_err_s;
    end
  end

  assign bus.load_err = load_err_r;
`else
  assign bus.load_err = 1'b0;
`endif

  assign bus.coef_ready = coef_ready_r;
  assign bus.busy       = busy_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.swap_done  = swap_done_r;
  assign bus.h          = bank_r;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: table of load vectors plus reset/boot/checksum sequences.
module tb_fir_coef_ctrl;
  import fir_pkg::*;

  localparam int N = FIR_NUMBER_OF_TAPS;
  localparam int W = FIR_DATA_WIDTH;
`ifdef FIR_COEF_CHECKSUM_EN
  localparam int NB       = N + 1;
  localparam int EXP_ERRS = 1;
`else
  localparam int NB       = N;
  localparam int EXP_ERRS = 0;
`endif

  typedef logic signed [W-1:0] coef_t;
  typedef struct {
    int    gap;
    bit    poke;
    bit    neg;
    int    exp_ready;
    coef_t exp_h0;
    coef_t exp_hl;
    int    exp_settle;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    vecs = 0;
  int    errs = 0;
  int    err_seen = 0;
  int    ready_cyc, ov_low_load, accepted;
  coef_t model_h [N];
  coef_t beat_v  [NB];
  vec_t  vt [4];

  always #5 clk = ~clk;

  fir_coef_ctrl_if #(.NUMBER_OF_TAPS(N), .DATA_WIDTH(W)) bus ();

  fir_coef_ctrl #(.NUMBER_OF_TAPS(N), .DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.load_err === 1'b1) err_seen++;
  end

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_h_model(input string name);
    int mism = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.h[i] !== model_h[i]) mism++;
    end
    check(name, mism, 0);
  endtask

  task automatic fill_beats(input bit neg);
    for (int i = 0; i < N; i++) begin
      beat_v[i] = neg ? coef_t'(-(i + 1)) : coef_t'(i + 1);
    end
`ifdef FIR_COEF_CHECKSUM_EN
    beat_v[N] = '0;
    for (int i = 0; i < N; i++) beat_v[N] = beat_v[N] + beat_v[i];
`endif
  endtask

  // Pulse load_start, then offer beats; valid follows the gap pattern counted in LOAD cycles.
  task automatic feed(input int gap, input bit poke, input int stop_after);
    int cyc = 0;
    bit held_chk = 1'b0;
    bit v;
    accepted = 0;
    ready_cyc = 0;
    ov_low_load = 0;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    while (accepted < stop_after && cyc < 1000) begin
      bus.load_start = 1'b0;
      bus.coef_valid = 1'b0;
      if (bus.coef_ready === 1'b1) begin
        v = ((ready_cyc % (gap + 1)) == gap);
        ready_cyc++;
        if (bus.out_valid !== 1'b1) ov_low_load++;
        if (!held_chk && accepted == 30) begin
          held_chk = 1'b1;
          check("h_held_during_load", int'(bus.h[0]), int'(model_h[0]));
        end
        if (poke && ready_cyc == 10) bus.load_start = 1'b1;
        bus.coef_valid = v;
        bus.coef_data  = beat_v[accepted];
        if (v) accepted++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.coef_valid = 1'b0;
    bus.load_start = 1'b0;
    check("beats_accepted", accepted, stop_after);
  endtask

  // Called in the SWAP cycle: check the new bank, then measure the settle window.
  task automatic expect_swap(input coef_t e0, input coef_t el, input int exp_settle, input bit poke);
    int low = 0;
    int sw = 0;
    check("swap_done_pulse", int'(bus.swap_done), 1);
    check("coef_ready_in_swap", int'(bus.coef_ready), 0);
    check("out_valid_in_swap", int'(bus.out_valid), 0);
    for (int i = 0; i < N; i++) model_h[i] = beat_v[i];
    check_h_model("h_bank_mismatches");
    check("h_first", int'(bus.h[0]), int'(e0));
    check("h_last", int'(bus.h[N-1]), int'(el));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.load_start = (poke && c == 5);
      if (bus.swap_done === 1'b1) sw++;
      if (bus.out_valid === 1'b1) break;
      low++;
    end
    bus.load_start = 1'b0;
    check("settle_length", low, exp_settle);
    check("swap_done_extra", sw, 0);
    check("busy_after_settle", int'(bus.busy), 0);
  endtask

  // Release reset on a negedge; that cycle counts as the first low out_valid cycle.
  task automatic boot_settle();
    int low = 1;
    int rdy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("out_valid_at_release", int'(bus.out_valid), 0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.coef_valid = 1'b1;
      bus.coef_data  = coef_t'(5);
      if (bus.coef_ready === 1'b1) rdy++;
      if (bus.out_valid === 1'b1) break;
      low++;
    end
    bus.coef_valid = 1'b0;
    check("boot_settle_length", low, N);
    check("coef_ready_in_boot", rdy, 0);
    check("busy_after_boot", int'(bus.busy), 0);
    check_h_model("h_zero_after_boot");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load_start = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    for (int i = 0; i < N; i++) model_h[i] = '0;

    vt[0] = '{gap: 0, poke: 1'b0, neg: 1'b0, exp_ready: NB,     exp_h0: coef_t'(1),  exp_hl: coef_t'(63),  exp_settle: N};
    vt[1] = '{gap: 1, poke: 1'b0, neg: 1'b0, exp_ready: 2 * NB, exp_h0: coef_t'(1),  exp_hl: coef_t'(63),  exp_settle: N};
    vt[2] = '{gap: 0, poke: 1'b1, neg: 1'b0, exp_ready: NB,     exp_h0: coef_t'(1),  exp_hl: coef_t'(63),  exp_settle: N};
    vt[3] = '{gap: 2, poke: 1'b0, neg: 1'b1, exp_ready: 3 * NB, exp_h0: coef_t'(-1), exp_hl: coef_t'(-63), exp_settle: N};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_coef_ready", int'(bus.coef_ready), 0);
    check("rst_swap_done", int'(bus.swap_done), 0);
    check("rst_load_err", int'(bus.load_err), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check_h_model("rst_h_zero");

    boot_settle();

    for (int k = 0; k < 4; k++) begin
      fill_beats(vt[k].neg);
      feed(vt[k].gap, vt[k].poke, NB);
      check("load_ready_cycles", ready_cyc, vt[k].exp_ready);
      check("out_valid_low_in_load", ov_low_load, 0);
      expect_swap(vt[k].exp_h0, vt[k].exp_hl, vt[k].exp_settle, vt[k].poke);
    end

    // Reset in the middle of a load: partial data discarded, bank cleared.
    fill_beats(1'b0);
    feed(0, 1'b0, 30);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) model_h[i] = '0;
    check_h_model("midload_rst_h_zero");
    check("midload_rst_busy", int'(bus.busy), 0);
    check("midload_rst_coef_ready", int'(bus.coef_ready), 0);
    check("midload_rst_out_valid", int'(bus.out_valid), 0);
    boot_settle();
    fill_beats(1'b0);
    feed(0, 1'b0, NB);
    check("reload_ready_cycles", ready_cyc, NB);
    expect_swap(coef_t'(1), coef_t'(63), N, 1'b0);

`ifdef FIR_COEF_CHECKSUM_EN
    // Bad checksum on all-ones taps: discarded, bank keeps 1..63.
    for (int i = 0; i < N; i++) beat_v[i] = coef_t'(1);
    beat_v[N] = coef_t'(10'h000);
    feed(0, 1'b0, NB);
    check("csum_bad_load_err", int'(bus.load_err), 1);
    check("csum_bad_swap_done", int'(bus.swap_done), 0);
    check("csum_bad_out_valid", int'(bus.out_valid), 1);
    check("csum_bad_busy", int'(bus.busy), 0);
    check_h_model("csum_bad_h_unchanged");
    @(negedge clk);
    check("csum_bad_err_one_cycle", int'(bus.load_err), 0);
    beat_v[N] = coef_t'(10'h03F);
    feed(0, 1'b0, NB);
    expect_swap(coef_t'(1), coef_t'(1), N, 1'b0);
`endif

    check("load_err_total", err_seen, EXP_ERRS);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
